// File: rtl/mux_rr_stream.sv
// Registered N-channel valid/ready stream multiplexer with round-robin or fixed-select
// arbitration; the chosen word is registered together with its source channel index.
module mux_rr_stream #(
   parameter int unsigned N_CH  = 4,
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CH_W  = $clog2(N_CH),
   parameter int unsigned CNT_W = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    mode,
   input  logic [CH_W-1:0]         sel,
   input  logic [N_CH-1:0]         in_valid,
   input  logic [N_CH*WIDTH-1:0]   in_data,
   output logic [N_CH-1:0]         in_ready,
   output logic                    out_valid,
   output logic [WIDTH-1:0]        out_data,
   output logic [CH_W-1:0]         out_ch,
   input  logic                    out_ready,
   output logic [CNT_W-1:0]        xfer_cnt
);

   logic [CH_W-1:0]  rr_ptr;
   logic [CH_W-1:0]  grant;
   logic             grant_valid;
   logic             slot_free;
   logic             accept;
   logic [WIDTH-1:0] ch_data [N_CH];
   logic [WIDTH-1:0] grant_data;
   logic [CH_W-1:0]  rr_next;

   // Channel index at distance off from base, modulo N_CH.
   function automatic logic [CH_W-1:0] rr_idx(input logic [CH_W-1:0] base, input int off);
      int s;
      s = int'(base) + off;
      if (s >= int'(N_CH)) s = s - int'(N_CH);
      return CH_W'(s);
   endfunction

   always_comb begin
      for (int i = 0; i < int'(N_CH); i++) begin
         ch_data[i] = in_data[i*WIDTH +: WIDTH];
      end
   end

   // Grant: scan descending so the lowest offset from rr_ptr wins.
   always_comb begin
      grant_valid = 1'b0;
      grant       = '0;
      if (!mode) begin
         for (int k = int'(N_CH) - 1; k >= 0; k--) begin
            if (in_valid[rr_idx(rr_ptr, k)]) begin
               grant_valid = 1'b1;
               grant       = rr_idx(rr_ptr, k);
            end
         end
      end else if ((32'(sel) < N_CH) && in_valid[sel]) begin
         grant_valid = 1'b1;
         grant       = sel;
      end
   end

   assign slot_free  = !out_valid || out_ready;
   assign accept     = grant_valid && slot_free && rst_n;
   assign in_ready   = accept ? (N_CH'(1) << grant) : '0;
   assign grant_data = ch_data[grant];
   assign rr_next    = (grant == CH_W'(N_CH - 1)) ? '0 : grant + CH_W'(1);

   // Output register, transfer counter and round-robin pointer.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_ch    <= '0;
         xfer_cnt  <= '0;
         rr_ptr    <= '0;
      end else if (accept) begin
         out_valid <= 1'b1;
         out_data  <= grant_data;
         out_ch    <= grant;
         xfer_cnt  <= xfer_cnt + CNT_W'(1);
         if (!mode) rr_ptr <= rr_next;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mux_rr_stream.sv
// Directed bench for mux_rr_stream: reset, round-robin, skip, backpressure,
// fixed-select and reset-during-stall sequences with hand-computed expectations.
module tb_mux_rr_stream;

   localparam int unsigned N_CH  = 4;
   localparam int unsigned WIDTH = 8;
   localparam int unsigned CH_W  = 2;
   localparam int unsigned CNT_W = 16;

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic                  mode;
   logic [CH_W-1:0]       sel;
   logic [N_CH-1:0]       in_valid;
   logic [N_CH*WIDTH-1:0] in_data;
   logic [N_CH-1:0]       in_ready;
   logic                  out_valid;
   logic [WIDTH-1:0]      out_data;
   logic [CH_W-1:0]       out_ch;
   logic                  out_ready;
   logic [CNT_W-1:0]      xfer_cnt;

   int n_pass  = 0;
   int n_total = 0;

   mux_rr_stream #(.N_CH(N_CH), .WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .mode      (mode),
      .sel       (sel),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ch    (out_ch),
      .out_ready (out_ready),
      .xfer_cnt  (xfer_cnt)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic chk_out(input string tag, input logic v, input logic [7:0] d,
                          input logic [1:0] ch, input logic [15:0] cnt);
      chk({tag, ".valid"}, 32'(out_valid), 32'(v));
      chk({tag, ".data"},  32'(out_data),  32'(d));
      chk({tag, ".ch"},    32'(out_ch),    32'(ch));
      chk({tag, ".cnt"},   32'(xfer_cnt),  32'(cnt));
   endtask

   task automatic set_default_data();
      in_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
   endtask

   initial begin
      rst_n     = 1'b0;
      mode      = 1'b0;
      sel       = '0;
      in_valid  = 4'b1111;
      out_ready = 1'b1;
      set_default_data();

      // 1: reset with all channels valid
      #1;
      chk("rst.ready0", 32'(in_ready), 32'h0);
      tick();
      chk_out("rst.e1", 1'b0, 8'h00, 2'd0, 16'd0);
      chk("rst.ready1", 32'(in_ready), 32'h0);
      tick();
      chk_out("rst.e2", 1'b0, 8'h00, 2'd0, 16'd0);
      chk("rst.ready2", 32'(in_ready), 32'h0);

      // 2: round-robin fairness, one word per cycle
      rst_n = 1'b1;
      #1;
      chk("rr.ready_init", 32'(in_ready), 32'h1);
      for (int i = 0; i < 8; i++) begin
         tick();
         chk_out($sformatf("rr.w%0d", i), 1'b1, 8'hA0 + 8'(i % 4), 2'(i % 4), 16'(i + 1));
         chk($sformatf("rr.ready%0d", i), 32'(in_ready), 32'(1) << ((i + 1) % 4));
      end

      // 3: skip idle channels 0 and 2
      in_valid = 4'b1010;
      #1;
      chk("skip.ready_init", 32'(in_ready), 32'h2);
      tick();
      chk_out("skip.w0", 1'b1, 8'hA1, 2'd1, 16'd9);
      chk("skip.ready0", 32'(in_ready), 32'h8);
      tick();
      chk_out("skip.w1", 1'b1, 8'hA3, 2'd3, 16'd10);
      chk("skip.ready1", 32'(in_ready), 32'h2);
      tick();
      chk_out("skip.w2", 1'b1, 8'hA1, 2'd1, 16'd11);
      chk("skip.ready2", 32'(in_ready), 32'h8);

      // drain: no grant, out_valid drops, data/ch hold
      in_valid = 4'b0000;
      tick();
      chk_out("drain", 1'b0, 8'hA1, 2'd1, 16'd11);

      // 4: backpressure after accepting ch0 = 8'h55 (rr_ptr is 2 here)
      in_valid = 4'b0001;
      in_data  = {8'hA3, 8'hA2, 8'hA1, 8'h55};
      #1;
      chk("bp.ready_init", 32'(in_ready), 32'h1);
      tick();
      chk_out("bp.first", 1'b1, 8'h55, 2'd0, 16'd12);
      out_ready = 1'b0;
      in_data   = {8'hA3, 8'hA2, 8'hA1, 8'h56};
      #1;
      chk("bp.ready_stall", 32'(in_ready), 32'h0);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk_out($sformatf("bp.hold%0d", i), 1'b1, 8'h55, 2'd0, 16'd12);
         chk($sformatf("bp.ready%0d", i), 32'(in_ready), 32'h0);
      end
      out_ready = 1'b1;
      #1;
      chk("bp.ready_release", 32'(in_ready), 32'h1);
      tick();
      chk_out("bp.next", 1'b1, 8'h56, 2'd0, 16'd13);

      // 5: fixed select, sel=2 (rr_ptr stays 1)
      mode     = 1'b1;
      sel      = 2'd2;
      in_valid = 4'b1111;
      set_default_data();
      #1;
      chk("fix.ready_init", 32'(in_ready), 32'h4);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_out($sformatf("fix.w%0d", i), 1'b1, 8'hA2, 2'd2, 16'(14 + i));
         chk($sformatf("fix.ready%0d", i), 32'(in_ready), 32'h4);
      end
      in_valid = 4'b1011;
      #1;
      chk("fix.noval_ready", 32'(in_ready), 32'h0);
      tick();
      chk_out("fix.noacc", 1'b0, 8'hA2, 2'd2, 16'd16);
      // switch back to round-robin: pointer left at 1 by the last RR accept
      mode = 1'b0;
      #1;
      chk("fix.mode_switch_ready", 32'(in_ready), 32'h2);
      tick();
      chk_out("fix.rr_resume", 1'b1, 8'hA1, 2'd1, 16'd17);

      // 6: reset while output is stalled
      out_ready = 1'b0;
      in_valid  = 4'b1111;
      tick();
      chk_out("mid.stall", 1'b1, 8'hA1, 2'd1, 16'd17);
      rst_n = 1'b0;
      #1;
      chk("mid.ready_rst", 32'(in_ready), 32'h0);
      tick();
      chk_out("mid.rst", 1'b0, 8'h00, 2'd0, 16'd0);
      rst_n     = 1'b1;
      out_ready = 1'b1;
      #1;
      chk("mid.ready_restart", 32'(in_ready), 32'h1);
      tick();
      chk_out("mid.restart", 1'b1, 8'hA0, 2'd0, 16'd1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
